// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, defaults and
// the ASCII control characters the upstream sequencer emits.
package uart_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_DATA  = 4'b0100,
    S_STOP  = 4'b1000
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT    = 10417;
  localparam int DEFAULT_FIFO_DEPTH_LOG2 = 5;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; dout shows the head entry so a pop
// and its data load happen in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [WIDTH-1:0]      i_din,
  input  logic                  i_rd_en,
  output logic [WIDTH-1:0]      o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  // A pop in the same cycle frees a slot, so a write into a full FIFO is
  // still accepted when it coincides with a read.
  assign w_rd_ok = i_rd_en & ~r_empty;
  assign w_wr_ok = i_wr_en & (~r_full | w_rd_ok);

  always_comb begin
    w_count_next = r_count;
    if (w_wr_ok & ~w_rd_ok) begin
      w_count_next = r_count + 1'b1;
    end else if (w_rd_ok & ~w_wr_ok) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH);
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO that absorbs character bursts from
// the message sequencer.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH_LOG2 = DEFAULT_FIFO_DEPTH_LOG2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sign,
  input  logic       tick,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic [15:0]          r_baud;
  logic [15:0]          w_baud_next;
  logic [2:0]           r_bit;
  logic [2:0]           w_bit_next;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_next;
  logic                 w_pop;
  logic                 w_bit_end;
  logic [7:0]           w_dout;
  logic                 w_full;
  logic                 w_empty;
  logic [FIFO_DEPTH_LOG2:0] w_count;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_overflow;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr_en (tick),
    .i_din   (sign),
    .i_rd_en (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_bit_end = (r_baud == BAUD_LAST);

  // The baud counter restarts on every state entry so frames never drift.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud + 16'd1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_dout;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_baud_next  = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // tx and busy are registered from the current state, so the line trails the
  // FSM by one cycle: start bit falls two edges after the write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud     <= w_baud_next;
      r_bit      <= w_bit_next;
      r_tx       <= (r_state == S_START) ? 1'b0 :
                    (r_state == S_DATA)  ? r_shift[0] : 1'b1;
      r_busy     <= (r_state != S_IDLE) | (w_count != '0);
      r_overflow <= r_overflow | (tick & w_full & ~w_pop);
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_next;
  end

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign fifo_full = w_full;
  assign overflow  = r_overflow;

endmodule
